program_sequencer: RTL
======================

# program_sequencer

Program counter and subroutine-stack sequencer that feeds instructions to the 1-bit ICU. It drives the program-memory address and splits each program word into a 4-bit opcode for the ICU and an address operand. It consumes the ICU's `jmp`, `rtn`, `flag_o` and `flag_f` strobes to implement jumps, calls, returns and halt. It is the fetch stage directly upstream of the ICU.

## Interface
- `ADDR_W`, 8, program address width; also the operand field width
- `STACK_DEPTH`, 4, return-stack entries (≥1)
- `clk`  in  1  system clock; the ICU shares it
- `rst`  in  1  synchronous, active-low reset; clock clk. The top level drives the ICU's active-high reset with `~rst`.
- `prog_addr`  out  ADDR_W  program memory address; equals `pc`
- `prog_data`  in  4+ADDR_W  asynchronous program memory word
  - `[3:0]` is the opcode
  - `[4+:ADDR_W]` is the operand
- `instruction`  out  4  `prog_data[3:0]`, combinational, to the ICU
- `jmp`, `rtn`, `flag_o`, `flag_f`  in  1 each  ICU strobes, valid in the low phase of clk
- `resume`  in  1  leave HALT; single-cycle pulse
- `halted`  out  1  state == HALT
- `sp`  out  clog2(STACK_DEPTH+1)  current stack occupancy
- `stk_err`  out  1  sticky stack overflow/underflow flag

## Operation
- Opcodes: NOPO=0, LD=1 … STO=8, STOC=9, IEN=A, OEN=B, JMP=C, RTN=D, SKZ=E, NOPF=F.
- Registers: `pc`, `state` {RUN, HALT}, `call_pending`, the stack array, `sp`, `stk_err`.
- All state updates happen on posedge clk.
- The ICU latches `instruction` at negedge and raises its strobes from that latched opcode. At the following posedge, `pc` still addresses the same word, so `prog_data` operand = jump target.
- RUN, priority order at posedge:
  1. `flag_o`: go to HALT; `pc` holds.
  2. `rtn`:
     - stack non-empty: `pc <= stack[sp-1]`, `sp--`.
     - stack empty: `pc <= pc+1`, `stk_err <= 1`.
  3. `jmp`: `pc <= operand`.
     - If `call_pending`, also push the current `pc` (the JMP's own address).
     - Push with stack full: push dropped, jump still taken, `stk_err <= 1`.
  4. Otherwise: `pc <= pc+1`, wrapping from 2^ADDR_W−1 to 0.
- `call_pending <= flag_f` every RUN posedge. NOPF immediately followed by JMP is a CALL; a plain JMP never pushes.
- Return lands on the CALL's JMP word. The ICU skips the instruction after RTN, so that JMP is not re-executed and execution continues at JMP address + 1. This is intentional; do not push `pc+1`.
- HALT:
  - `pc` and the stack are frozen; all strobes are ignored.
  - `resume` gives `pc <= pc+1`, go to RUN, `call_pending <= 0`.
- `resume` in RUN is ignored.
- `jmp` and `rtn` are mutually exclusive by opcode. If both arrive anyway, `rtn` wins.
- `stk_err` clears only on reset.

## Timing
- Reset (`rst`=0 at posedge): `pc`=0, `sp`=0, state RUN, `call_pending`=0, `stk_err`=0.
  - Outputs: `prog_addr`=0, `halted`=0, `sp`=0, `stk_err`=0.
  - `instruction` tracks `prog_data[3:0]` at all times, including during reset.
- First posedge with `rst`=1: the ICU has latched a word from address 0 only if a negedge occurred after reset released. Address 0 is fetched once more, so program word 0 executes exactly once.
- Sequential fetch: one instruction per clk; `prog_addr` changes only at posedge.
- Jump/return latency: target address presented one posedge after the JMP/RTN word was latched, i.e. a zero-bubble redirect.
- Halt latency: `halted` rises at the posedge after NOPO is latched. `resume` sampled at posedge gives fetch of the next word from that edge.
- Reset asserted mid-CALL or mid-HALT: everything returns to reset values at that posedge; the stack contents are discarded.

## Test plan
- Reset, program 0:1,1:8,2:1 (LD, STO, LD) → `prog_addr` 0,1,2,3 on successive posedges; `sp`=0; `stk_err`=0.
- JMP: word 3 = JMP operand 0x40 → after address 3, `prog_addr`=0x40; `sp` stays 0.
- CALL/RTN: word 5=NOPF, 6=JMP 0x80, 0x80=LD, 0x81=RTN.
  - Sequence 5,6,0x80,0x81,6,7; `sp` 0→1→0.
  - The ICU suppresses the second execution of word 6.
- Overflow with STACK_DEPTH=2: three nested CALLs → third jump taken, `sp` stays 2, `stk_err`=1. Underflow: RTN with `sp`=0 → `pc+1`, `stk_err`=1.
- Halt: word 9 = NOPO → `halted`=1, `prog_addr` holds 9 for 5 cycles; `resume` pulse → `prog_addr`=10, `halted`=0.
- Wrap and reset: `ADDR_W`=4, run linear code → `prog_addr` 15→0. Drop `rst` while `sp`=1 → `pc`=0, `sp`=0.

Source files
------------

// File: rtl/program_sequencer.sv
// program_sequencer: program counter and return stack feeding opcodes and jump targets to the 1-bit ICU
module program_sequencer #(
  parameter int ADDR_W = 8,
  parameter int STACK_DEPTH = 4,
  localparam int SP_W = $clog2(STACK_DEPTH + 1),
  localparam int IDX_W = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] prog_addr,
  input  logic [ADDR_W+3:0] prog_data,
  output logic [3:0]        instruction,
  input  logic              jmp,
  input  logic              rtn,
  input  logic              flag_o,
  input  logic              flag_f,
  input  logic              resume,
  output logic              halted,
  output logic [SP_W-1:0]   sp,
  output logic              stk_err
);
  typedef enum logic {RUN, HALT} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [SP_W-1:0] sp_q, sp_d;
  logic call_pending_q, call_pending_d;
  logic stk_err_q, stk_err_d;
  logic push;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0] operand;
  logic [IDX_W-1:0] top_idx, push_idx;
  assign operand = prog_data[4 +: ADDR_W];
  assign top_idx = IDX_W'(sp_q - SP_W'(1));
  assign push_idx = IDX_W'(sp_q);
  assign prog_addr = pc_q;
  assign instruction = prog_data[3:0];
  assign halted = state_q == HALT;
  assign sp = sp_q;
  assign stk_err = stk_err_q;
  // Next pc, stack pointer and run/halt state from the ICU strobes; the return address pushed is the JMP's own word
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    sp_d = sp_q;
    call_pending_d = call_pending_q;
    stk_err_d = stk_err_q;
    push = 1'b0;
    if (state_q == HALT) begin
      if (resume) begin
        pc_d = pc_q + ADDR_W'(1);
        state_d = RUN;
        call_pending_d = 1'b0;
      end
    end else begin
      call_pending_d = flag_f;
      if (flag_o) begin
        state_d = HALT;
      end else if (rtn) begin
        if (sp_q != '0) begin
          pc_d = stack_q[top_idx];
          sp_d = sp_q - SP_W'(1);
        end else begin
          pc_d = pc_q + ADDR_W'(1);
          stk_err_d = 1'b1;
        end
      end else if (jmp) begin
        pc_d = operand;
        if (call_pending_q) begin
          if (sp_q == SP_W'(STACK_DEPTH)) begin
            stk_err_d = 1'b1;
          end else begin
            push = 1'b1;
            sp_d = sp_q + SP_W'(1);
          end
        end
      end else begin
        pc_d = pc_q + ADDR_W'(1);
      end
    end
  end
  // Control registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      pc_q <= '0;
      sp_q <= '0;
      call_pending_q <= 1'b0;
      stk_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      sp_q <= sp_d;
      call_pending_q <= call_pending_d;
      stk_err_q <= stk_err_d;
    end
  end
  // Return stack storage; contents are meaningless once sp is reset
  always_ff @(posedge clk) begin
    if (rst && push) stack_q[push_idx] <= pc_q;
  end
endmodule
